clk_div_sched: RTL and testbench

//  Run-time controller for the system clock divider: holds the active half-period divisor and

---
 rtl/clk_div_sched_pkg.sv | 14 +
 rtl/clk_div_sched_if.sv | 28 ++
 rtl/clk_half_counter.sv | 38 +++
 rtl/clk_div_sched.sv | 136 +++++++++++++
 tb/tb_clk_div_sched.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_sched_pkg.sv
// clk_div_sched_pkg: shared FSM encodings and defaults for divider clients.
// Holds the state enum, the default counter width and the reset half-period.
package clk_div_sched_pkg;

  localparam int CNT_W_DEF        = 16;
  localparam int DEFAULT_HALF_DEF = 5000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_sched_if.sv
// clk_div_sched_if: divisor config handshake (valid/ready) plus error pulse.
// master drives cfg_valid/cfg_div; slave returns cfg_ready/cfg_err.
interface clk_div_sched_if
  import clk_div_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_half_counter.sv
// clk_half_counter: half-period counter; in clk_in/rst/clr/run/half.
// out: wrap (cnt==half-1 while run) and the cnt register.
module clk_half_counter
  import clk_div_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             wrap,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap = run && (cnt_q == half - ONE);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = wrap ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: glitch-free run/stop clock divider with handshaked divisor swap.
// in: clk_in, rst, en, cfg (slave); out: clk_out, tick, running.
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           en,
  clk_div_sched_if.slave cfg,
  output logic           clk_out,
  output logic           tick,
  output logic           running
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             run, clr, wrap;
  logic             xfer, zero, fall;
  logic             stop_low, apply;
  logic [CNT_W-1:0] cnt;

  clk_half_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clr),
    .run    (run),
    .half   (half_q),
    .wrap   (wrap),
    .cnt    (cnt)
  );

  assign cfg.cfg_ready = ~pend_v_q;
  assign cfg.cfg_err   = err_q;
  assign clk_out       = clk_q;
  assign tick          = tick_q;
  assign running       = (state_q != IDLE);

  assign xfer     = cfg.cfg_valid && !pend_v_q;
  assign zero     = (cfg.cfg_div == '0);
  assign fall     = wrap && clk_q;
  assign stop_low = (state_q == STOP) && !en && !clk_q;
  // A parked divisor lands only on a whole-period boundary
  // or once the output is known to be parked low.
  assign apply    = pend_v_q &&
                    (fall || stop_low || state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    err_d    = xfer && zero;
    run      = 1'b0;
    clr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (en) state_d = RUN;
      end
      RUN: begin
        run = 1'b1;
        if (!en) state_d = STOP;
      end
      STOP: begin
        if (en) begin
          run     = 1'b1;
          state_d = RUN;
        end else if (clk_q) begin
          run = 1'b1;
          if (wrap) state_d = IDLE;
        end else begin
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE)
      clk_d = 1'b0;
    else if (wrap)
      clk_d = ~clk_q;
    tick_d = wrap && !clk_q;

    // apply needs pend_v_q=1, which blocks xfer: never both.
    if (apply) begin
      half_d   = pend_q;
      pend_v_d = 1'b0;
    end else if (xfer && !zero) begin
      if (state_q == IDLE) begin
        half_d = cfg.cfg_div;
      end else begin
        pend_d   = cfg.cfg_div;
        pend_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      half_q   <= CNT_W'(DEFAULT_HALF);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  cnt_in_range: assert property (
    @(posedge clk_in) disable iff (rst)
    cnt < half_q
  );

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: scoreboard bench for clk_div_sched (DEFAULT_HALF=5).
// Expected tick cycles and high widths are queued ahead and popped per tick.
module tb_clk_div_sched;
  import clk_div_sched_pkg::*;

  localparam int CW = 16;

  typedef struct {
    int c;
    int w;
  } exp_t;

  logic clk;
  logic rst;
  logic en;
  logic clk_out;
  logic tick;
  logic running;

  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t sb_q[$];

  clk_div_sched_if #(.CNT_W(CW)) cfg_if ();

  clk_div_sched #(
    .CNT_W        (CW),
    .DEFAULT_HALF (5)
  ) dut (
    .clk_in  (clk),
    .rst     (rst),
    .en      (en),
    .cfg     (cfg_if.slave),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic push(input int c, input int w);
    exp_t e;
    e.c = c;
    e.w = w;
    sb_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: tick timing vs scoreboard, tick on every rise,
  // and high-phase width on every fall.
  initial begin
    logic prev;
    int   rise_c;
    int   hi_exp;
    exp_t e;
    prev   = 1'b0;
    rise_c = 0;
    hi_exp = 0;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("tick_extra", cyc, 0);
        end else begin
          e = sb_q.pop_front();
          chk("tick_cyc", cyc, e.c);
          hi_exp = e.w;
        end
      end
      if (clk_out === 1'b1 && prev == 1'b0) begin
        chk("tick_at_rise", tick, 1);
        rise_c = cyc;
      end
      if (clk_out === 1'b0 && prev == 1'b1)
        chk("hi_width", cyc - rise_c, hi_exp);
      prev = (clk_out === 1'b1);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, p, q;
    rst              = 1'b1;
    en               = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    repeat (2) @(negedge clk);

    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_err", cfg_if.cfg_err, 0);
    chk("rst_run", running, 0);
    chk("rst_rdy", cfg_if.cfg_ready, 1);

    // Default half=5, then swap to 3 mid high phase,
    // then a zero divisor, then stop in a high phase.
    n   = cyc;
    rst = 1'b0;
    en  = 1'b1;
    push(n + 6, 5);
    push(n + 16, 5);
    push(n + 26, 5);
    push(n + 34, 3);
    push(n + 40, 3);
    push(n + 46, 3);
    push(n + 52, 3);
    wait_to(n + 3);
    chk("run_on", running, 1);
    wait_to(n + 27);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd3;
    wait_to(n + 28);
    chk("rdy_pend", cfg_if.cfg_ready, 0);
    cfg_if.cfg_valid = 1'b0;
    wait_to(n + 30);
    chk("rdy_hold", cfg_if.cfg_ready, 0);
    wait_to(n + 31);
    chk("rdy_free", cfg_if.cfg_ready, 1);

    wait_to(n + 41);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd0;
    wait_to(n + 42);
    chk("err_pulse", cfg_if.cfg_err, 1);
    chk("rdy_err", cfg_if.cfg_ready, 1);
    cfg_if.cfg_valid = 1'b0;
    wait_to(n + 43);
    chk("err_clr", cfg_if.cfg_err, 0);

    wait_to(n + 53);
    en = 1'b0;
    wait_to(n + 54);
    chk("stop_hi_run", running, 1);
    chk("stop_hi_clk", clk_out, 1);
    wait_to(n + 55);
    chk("stop_hi_idle", running, 0);
    chk("stop_hi_low", clk_out, 0);

    // Stop during the low phase: IDLE next cycle, no rise.
    m = n + 58;
    wait_to(m);
    en = 1'b1;
    wait_to(m + 2);
    en = 1'b0;
    wait_to(m + 3);
    chk("stop_lo_run", running, 1);
    wait_to(m + 4);
    chk("stop_lo_idle", running, 0);
    chk("stop_lo_clk", clk_out, 0);

    // en rise with half=1 in IDLE, then a stalled
    // second divisor while the first is pending.
    p = m + 6;
    wait_to(p);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd1;
    en               = 1'b1;
    push(p + 2, 1);
    push(p + 4, 1);
    push(p + 6, 1);
    push(p + 8, 1);
    push(p + 13, 4);
    push(p + 19, 2);
    push(p + 23, 2);
    wait_to(p + 1);
    cfg_if.cfg_valid = 1'b0;
    wait_to(p + 7);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd4;
    wait_to(p + 8);
    chk("rdy_stall", cfg_if.cfg_ready, 0);
    cfg_if.cfg_div = 16'd2;
    wait_to(p + 9);
    chk("rdy_reopen", cfg_if.cfg_ready, 1);
    wait_to(p + 10);
    chk("rdy_pend2", cfg_if.cfg_ready, 0);
    cfg_if.cfg_valid = 1'b0;

    // Reset in a low phase with a divisor pending.
    wait_to(p + 25);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'd7;
    wait_to(p + 26);
    chk("rdy_pend3", cfg_if.cfg_ready, 0);
    cfg_if.cfg_valid = 1'b0;
    rst              = 1'b1;
    wait_to(p + 27);
    chk("mrst_clk", clk_out, 0);
    chk("mrst_rdy", cfg_if.cfg_ready, 1);
    chk("mrst_run", running, 0);
    chk("mrst_tick", tick, 0);

    // Restart must repeat the default timing.
    q   = p + 27;
    rst = 1'b0;
    push(q + 6, 5);
    push(q + 16, 5);
    wait_to(q + 22);
    en = 1'b0;
    wait_to(q + 30);
    chk("end_idle", running, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
